// File: rtl/d64_trk_flush.sv
// Writes modified 512-byte SD blocks of the loaded D64 track back through the hps_io sd_* write handshake.
// sd_wr rises 2 cycles after a flush edge; each block waits on sd_ack, so the host paces the transfer.
module d64_trk_flush (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  track,
    input  logic [4:0]  sector,
    input  logic        buff_we,
    input  logic        discard,
    input  logic        flush,
    output logic [31:0] sd_lba,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_din,
    output logic [12:0] trk_addr,
    input  logic [7:0]  trk_q,
    output logic        busy,
    output logic        dirty
);

    typedef enum logic [1:0] {IDLE, SCAN, REQ, XFER} state_t;

    state_t      state, state_nxt;
    logic [10:0] mask, mask_nxt;
    logic [9:0]  start_l;
    logic [3:0]  k_l;
    logic        redirty;
    logic        flush_q;
    logic        ack_q;

    logic [9:0]  start_cur;
    logic [5:0]  sec_sum;
    logic [4:0]  k_cur;
    logic [12:0] fix_l;
    logic        trk_ok;
    logic        we_ok;
    logic        hit_l;
    logic        flush_rise;
    logic        ack_fall;

    // 256-byte sector index of each track's first sector within the D64 image
    function automatic logic [9:0] trk_start(input logic [5:0] t);
        case (t)
            6'd1:  trk_start = 10'd0;   6'd2:  trk_start = 10'd21;  6'd3:  trk_start = 10'd42;
            6'd4:  trk_start = 10'd63;  6'd5:  trk_start = 10'd84;  6'd6:  trk_start = 10'd105;
            6'd7:  trk_start = 10'd126; 6'd8:  trk_start = 10'd147; 6'd9:  trk_start = 10'd168;
            6'd10: trk_start = 10'd189; 6'd11: trk_start = 10'd210; 6'd12: trk_start = 10'd231;
            6'd13: trk_start = 10'd252; 6'd14: trk_start = 10'd273; 6'd15: trk_start = 10'd294;
            6'd16: trk_start = 10'd315; 6'd17: trk_start = 10'd336; 6'd18: trk_start = 10'd357;
            6'd19: trk_start = 10'd376; 6'd20: trk_start = 10'd395; 6'd21: trk_start = 10'd414;
            6'd22: trk_start = 10'd433; 6'd23: trk_start = 10'd452; 6'd24: trk_start = 10'd471;
            6'd25: trk_start = 10'd490; 6'd26: trk_start = 10'd508; 6'd27: trk_start = 10'd526;
            6'd28: trk_start = 10'd544; 6'd29: trk_start = 10'd562; 6'd30: trk_start = 10'd580;
            6'd31: trk_start = 10'd598; 6'd32: trk_start = 10'd615; 6'd33: trk_start = 10'd632;
            6'd34: trk_start = 10'd649; 6'd35: trk_start = 10'd666; 6'd36: trk_start = 10'd683;
            6'd37: trk_start = 10'd700; 6'd38: trk_start = 10'd717; 6'd39: trk_start = 10'd734;
            6'd40: trk_start = 10'd751;
            default: trk_start = 10'd0;
        endcase
    endfunction

    function automatic logic [3:0] lowest_bit(input logic [10:0] m);
        lowest_bit = 4'd0;
        for (int i = 10; i >= 0; i--) begin
            if (m[i]) lowest_bit = 4'(i);
        end
    endfunction

    // An odd track start shifts every SD block half a block earlier in the buffer
    assign start_cur   = trk_start(track);
    assign sec_sum     = {1'b0, sector} + {5'd0, start_cur[0]};
    assign k_cur       = sec_sum[5:1];
    assign trk_ok      = (track >= 6'd1) && (track <= 6'd40);
    assign we_ok       = buff_we && trk_ok && (k_cur <= 5'd10);
    assign hit_l       = we_ok && (k_cur == {1'b0, k_l});
    assign flush_rise  = flush && !flush_q;
    assign ack_fall    = ack_q && !sd_ack;
    assign fix_l       = start_l[0] ? 13'h1F00 : 13'h0000;
    assign trk_addr    = {k_l, 9'd0} + fix_l + {4'd0, sd_buff_addr};
    assign sd_buff_din = trk_q;
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (flush_rise && (mask != 11'd0) && trk_ok) state_nxt = SCAN;
            SCAN: state_nxt = (mask != 11'd0) ? REQ : IDLE;
            REQ:  if (sd_ack) state_nxt = XFER;
            XFER: if (ack_fall) state_nxt = SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    // A write landing on the block being sent keeps it dirty so the same pass resends it
    always_comb begin
        mask_nxt = mask;
        if ((state == XFER) && ack_fall && !redirty) mask_nxt[k_l] = 1'b0;
        if (we_ok) mask_nxt[k_cur[3:0]] = 1'b1;
        if ((state == IDLE) && discard) mask_nxt = 11'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask    <= 11'd0;
            dirty   <= 1'b0;
            flush_q <= 1'b0;
            ack_q   <= 1'b0;
            start_l <= 10'd0;
            k_l     <= 4'd0;
            sd_lba  <= 32'd0;
            sd_wr   <= 1'b0;
            redirty <= 1'b0;
        end else begin
            mask    <= mask_nxt;
            dirty   <= |mask;
            flush_q <= flush;
            ack_q   <= sd_ack;
            if ((state == IDLE) && (state_nxt == SCAN)) start_l <= start_cur;
            case (state)
                SCAN: begin
                    if (mask != 11'd0) begin
                        k_l     <= lowest_bit(mask);
                        sd_lba  <= {23'd0, start_l[9:1]} + {28'd0, lowest_bit(mask)};
                        sd_wr   <= 1'b1;
                        redirty <= 1'b0;
                    end
                end
                REQ: begin
                    if (sd_ack) sd_wr <= 1'b0;
                end
                XFER: begin
                    if (hit_l) redirty <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d64_trk_flush.sv
module tb_d64_trk_flush;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  track;
    logic [4:0]  sector;
    logic        buff_we, discard, flush, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  trk_q;
    logic [31:0] sd_lba;
    logic        sd_wr, busy, dirty;
    logic [7:0]  sd_buff_din;
    logic [12:0] trk_addr;

    always #5 clk = ~clk;

    d64_trk_flush dut (
        .clk(clk), .reset(reset), .track(track), .sector(sector), .buff_we(buff_we),
        .discard(discard), .flush(flush), .sd_lba(sd_lba), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_din(sd_buff_din), .trk_addr(trk_addr),
        .trk_q(trk_q), .busy(busy), .dirty(dirty)
    );

    logic [7:0] mem [8192];
    always @(posedge clk) trk_q <= mem[trk_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: dirty set as a bit vector, expectations for the host-visible outputs
    bit [10:0]   m_mask;
    bit          m_redirty, in_xfer, clr_req, check_en;
    bit          exp_wr, exp_busy, exp_dirty;
    logic [31:0] exp_lba;
    int          m_k, m_fix, m_base;
    int          wr_lbas[$];
    int          a256[$];

    function automatic int nsec(input int t);
        if (t <= 17) return 21;
        if (t <= 24) return 19;
        if (t <= 30) return 18;
        return 17;
    endfunction

    function automatic int tstart(input int t);
        int s = 0;
        for (int i = 1; i < t; i++) s += nsec(i);
        return s;
    endfunction

    function automatic int kof(input int t, input int s);
        return ((tstart(t) % 2) + s) / 2;
    endfunction

    function automatic int lowest(input bit [10:0] m);
        for (int i = 0; i < 11; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic bit trk_valid(input int t);
        return (t >= 1) && (t <= 40);
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("sd_wr", sd_wr, exp_wr);
            chk("busy", busy, exp_busy);
            chk("dirty", dirty, exp_dirty);
            if (exp_wr) chk("sd_lba", sd_lba, exp_lba);
        end
    end

    // One clock edge: apply the model effect of the inputs sampled at that edge
    task automatic step();
        bit busy_at_edge;
        int k;
        busy_at_edge = exp_busy;
        @(posedge clk);
        #1;
        if (reset) begin
            m_mask    = '0;
            exp_dirty = 1'b0;
            clr_req   = 1'b0;
            return;
        end
        exp_dirty = (m_mask != 0);
        if (clr_req && !m_redirty) m_mask[m_k] = 1'b0;
        if (buff_we && trk_valid(int'(track))) begin
            k = kof(int'(track), int'(sector));
            if (k <= 10) begin
                m_mask[k] = 1'b1;
                if (in_xfer && k == m_k) m_redirty = 1'b1;
            end
        end
        if (!busy_at_edge && discard) m_mask = '0;
        clr_req = 1'b0;
    endtask

    task automatic rand_in(input bit noisy);
        buff_we = 1'b0;
        discard = 1'b0;
        if (noisy) begin
            buff_we = ($urandom_range(0, 7) == 0);
            discard = ($urandom_range(0, 7) == 0);
            if (in_xfer && $urandom_range(0, 1) == 1 && 2 * m_k < nsec(int'(track)))
                sector = 5'(2 * m_k);
            else
                sector = 5'($urandom_range(0, nsec(int'(track)) - 1));
        end
    endtask

    // Flush plus host side of the write handshake.
    // mode 1: rewrite first block during its transfer; 2: discard+flush while busy; 3: reset in REQ
    task automatic do_flush(input int sweep_n, input bit noisy, input int mode);
        bit go, first;
        bit [10:0] pre;
        int a, n, ea;
        go = (m_mask != 0) && trk_valid(int'(track)) && !exp_busy;
        rand_in(1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        if (!go) begin
            step();
            step();
            return;
        end
        exp_busy = 1'b1;
        m_base   = tstart(int'(track)) / 2;
        m_fix    = (tstart(int'(track)) % 2 == 1) ? 'h1F00 : 0;
        first    = 1'b1;
        forever begin
            pre = m_mask;
            rand_in(noisy);
            step();
            if (pre == 0) begin
                exp_busy = 1'b0;
                return;
            end
            m_k       = lowest(pre);
            exp_lba   = 32'(m_base + m_k);
            exp_wr    = 1'b1;
            m_redirty = 1'b0;
            wr_lbas.push_back(m_base + m_k);
            if (mode == 3 && first) begin
                reset = 1'b1;
                #1;
                chk("rst_req_sd_wr", sd_wr, 0);
                chk("rst_req_busy", busy, 0);
                m_mask = '0; exp_wr = 0; exp_busy = 0; exp_dirty = 0;
                in_xfer = 0; m_redirty = 0; clr_req = 0;
                step();
                reset = 1'b0;
                step();
                return;
            end
            if (mode == 2 && first) begin
                rand_in(1'b0);
                discard = 1'b1;
                flush   = 1'b1;
                step();
                discard = 1'b0;
                flush   = 1'b0;
                step();
            end else begin
                n = $urandom_range(0, 3);
                repeat (n) begin
                    rand_in(noisy);
                    flush = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                    step();
                end
                flush = 1'b0;
            end
            rand_in(noisy);
            sd_ack = 1'b1;
            step();
            exp_wr  = 1'b0;
            in_xfer = 1'b1;
            for (int i = 0; i < sweep_n; i++) begin
                a = (sweep_n == 512) ? i : $urandom_range(0, 511);
                sd_buff_addr = 9'(a);
                rand_in(noisy);
                if (mode == 1 && first && i == 2) begin
                    buff_we = 1'b1;
                    sector  = 5'd2;
                end
                #1;
                ea = (m_k * 512 + m_fix + a) % 8192;
                chk("trk_addr", trk_addr, ea);
                if (a == 256) a256.push_back(int'(trk_addr));
                step();
                chk("sd_buff_din", sd_buff_din, mem[ea]);
            end
            rand_in(noisy);
            sd_ack  = 1'b0;
            clr_req = 1'b1;
            step();
            in_xfer = 1'b0;
            first   = 1'b0;
        end
    endtask

    task automatic write_sec(input int t, input int s);
        track   = 6'(t);
        sector  = 5'(s);
        buff_we = 1'b1;
        step();
        buff_we = 1'b0;
    endtask

    initial begin
        int nw, saved;
        reset = 1'b1; track = 6'd0; sector = 5'd0; buff_we = 0; discard = 0; flush = 0;
        sd_ack = 0; sd_buff_addr = 9'd0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        m_mask = '0; m_redirty = 0; in_xfer = 0; clr_req = 0; check_en = 0;
        exp_wr = 0; exp_busy = 0; exp_dirty = 0; exp_lba = '0; m_k = 0;
        repeat (3) step();
        chk("rst_sd_wr", sd_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dirty", dirty, 0);
        chk("rst_sd_lba", sd_lba, 0);
        chk("rst_trk_addr", trk_addr, 0);
        reset = 1'b0;
        step();
        check_en = 1'b1;

        // Track 1, sector 0: single write at LBA 0, full byte sweep
        write_sec(1, 0);
        step();
        wr_lbas.delete(); a256.delete();
        do_flush(512, 1'b0, 0);
        chk("t1_writes", wr_lbas.size(), 1);
        if (wr_lbas.size() >= 1) chk("t1_lba", wr_lbas[0], 0);
        step();
        chk("t1_busy_after", busy, 0);
        chk("t1_dirty_after", dirty, 0);

        // Track 18 (odd start): blocks wrap around the 8 KiB buffer
        write_sec(18, 0);
        write_sec(18, 1);
        step();
        wr_lbas.delete(); a256.delete();
        do_flush(512, 1'b0, 0);
        chk("t18_writes", wr_lbas.size(), 2);
        if (wr_lbas.size() >= 2) begin
            chk("t18_lba0", wr_lbas[0], 178);
            chk("t18_lba1", wr_lbas[1], 179);
        end
        if (a256.size() >= 2) begin
            chk("t18_addr0", a256[0], 'h0000);
            chk("t18_addr1", a256[1], 'h0200);
        end

        // Track 19: lowest block first regardless of write order
        write_sec(19, 20);
        write_sec(19, 3);
        step();
        wr_lbas.delete();
        do_flush(16, 1'b0, 0);
        chk("t19_writes", wr_lbas.size(), 2);
        if (wr_lbas.size() >= 2) begin
            chk("t19_lba0", wr_lbas[0], 189);
            chk("t19_lba1", wr_lbas[1], 198);
        end

        // Block re-dirtied during its transfer is rewritten in the same pass
        write_sec(1, 2);
        step();
        wr_lbas.delete();
        do_flush(32, 1'b0, 1);
        chk("redirty_writes", wr_lbas.size(), 2);
        if (wr_lbas.size() >= 2) begin
            chk("redirty_lba0", wr_lbas[0], 1);
            chk("redirty_lba1", wr_lbas[1], 1);
        end

        // Discard while idle clears a 0x005 mask
        write_sec(1, 0);
        write_sec(1, 4);
        step();
        chk("disc_dirty_before", dirty, 1);
        discard = 1'b1;
        step();
        discard = 1'b0;
        step();
        chk("disc_dirty_after", dirty, 0);

        // Discard and a flush edge while busy change nothing
        write_sec(1, 0);
        write_sec(1, 4);
        step();
        wr_lbas.delete();
        do_flush(16, 1'b0, 2);
        chk("busy_disc_writes", wr_lbas.size(), 2);
        if (wr_lbas.size() >= 2) begin
            chk("busy_disc_lba0", wr_lbas[0], 0);
            chk("busy_disc_lba1", wr_lbas[1], 2);
        end

        // Reset in REQ loses the mask; a later flush writes nothing
        write_sec(1, 0);
        step();
        do_flush(16, 1'b0, 3);
        wr_lbas.delete();
        do_flush(16, 1'b0, 0);
        chk("post_rst_writes", wr_lbas.size(), 0);
        chk("post_rst_busy", busy, 0);

        // Randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            track   = 6'($urandom_range(1, 40));
            discard = 1'b1;
            step();
            discard = 1'b0;
            nw = $urandom_range(1, 6);
            repeat (nw) write_sec(int'(track), $urandom_range(0, nsec(int'(track)) - 1));
            if ($urandom_range(0, 7) == 0) begin
                saved = int'(track);
                track = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(41, 63));
                write_sec(int'(track), $urandom_range(0, 20));
                if ($urandom_range(0, 1) == 1) track = 6'(saved);
            end
            step();
            do_flush(12, 1'b1, 0);
            rand_in(1'b0);
            repeat (2) step();
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/d64_trk_flush.md
# d64_trk_flush

Write-back companion to the track loader in the 1541 drive path. It tracks which 512-byte SD blocks of the currently loaded D64 track have been modified by the drive. On request, it writes those blocks back to the SD image through the hps_io sd_* write handshake, serving the outgoing bytes from the shared track buffer's SD-side port. It sits between the drive-side buffer write strobe, the track buffer RAM and the hps_io SD interface.

## Interface
Parameters: none; the 41-entry track start table (256-byte sector index, entry 0 = 0) is an internal constant identical to the loader's.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- track  in  6  track currently loaded in the buffer; valid 1..40
- sector  in  5  drive-side sector of the current buffer write
- buff_we  in  1  drive-side buffer write strobe; marks a block dirty
- discard  in  1  level; while high and idle, clears the dirty mask (new track loaded)
- flush  in  1  level; a rising edge starts write-back
- sd_lba  out  32  LBA of the block being written
- sd_wr  out  1  write request to hps_io
- sd_ack  in  1  hps_io transfer acknowledge
- sd_buff_addr  in  9  byte index within the 512-byte block requested by hps_io
- sd_buff_din  out  8  byte to hps_io; equals trk_q
- trk_addr  out  13  read address to the track buffer SD-side port
- trk_q  in  8  track buffer read data (registered RAM, 1-cycle latency)
- busy  out  1  write-back in progress
- dirty  out  1  OR of the dirty mask

## Operation
- start = table[track]; odd = start[0]; base_lba = start[9:1]; fix = odd ? 13'h1F00 : 0.
- Dirty block index of a buffer write: k = (odd + sector) >> 1, range 0..10; 11-bit dirty mask.
- buff_we sets mask[k] in every state. Writes with track outside 1..40 are ignored.
- Block k occupies buffer bytes (k*512 + fix + sd_buff_addr) mod 8192. This sum is trk_addr, computed combinationally from the latched k and the live sd_buff_addr. sd_buff_din = trk_q.
- FSM:
  - IDLE: on a flush rising edge with mask != 0 and track in 1..40, latch trk_l = track and go to SCAN; otherwise stay. Flush with mask == 0 leaves busy at 0.
  - SCAN: k_l = lowest set bit of mask; sd_lba = base_lba(trk_l) + k_l; sd_wr = 1; redirty = 0; go to REQ. If mask == 0, go to IDLE.
  - REQ: hold sd_wr until sd_ack = 1, then clear sd_wr and go to XFER.
  - XFER: a buff_we mapping to k_l sets redirty. On the sd_ack falling edge, clear mask[k_l] unless redirty or a same-cycle buff_we hits k_l, then go to SCAN.
- busy = 1 in SCAN, REQ and XFER. Redirtied blocks are rewritten in the same flush pass (SCAN picks them again).
- discard is honoured only in IDLE and has priority over a simultaneous buff_we; it is ignored while busy.
- A flush edge while busy is ignored. The flush edge detector still updates.

## Timing
- Reset values: sd_wr 0, busy 0, dirty 0, sd_lba 0, mask 0, FSM IDLE, trk_addr 0.
- flush edge at cycle N: busy = 1 at N+1; sd_wr = 1 and sd_lba valid at N+2.
- sd_wr drops in the cycle after sd_ack is first seen high.
- Between a block's sd_ack fall and the next block's sd_wr rise: 2 cycles (XFER→SCAN→REQ).
- busy drops 2 cycles after the last sd_ack fall.
- trk_addr follows sd_buff_addr combinationally; trk_q is valid 1 cycle later. The hps_io write path tolerates this latency.
- dirty is registered and updates the cycle after a mask change.
- Reset mid-transfer aborts immediately (sd_wr 0, mask lost). The host side times out on its own.

## Test plan
- Track 1, buff_we sector 0, flush: one write, sd_lba 0; sd_buff_addr 0..511 read trk_addr 0x0000..0x01FF; then busy 0, dirty 0.
- Track 18 (start 357, odd), buff_we sectors 0 and 1, flush: sd_lba 178 with trk_addr base 0x1F00 (sd_buff_addr 0x100 → 0x0000), then sd_lba 179 with base 0x0100.
- Track 19, buff_we sectors 20 and 3, flush: writes in order lba 189 (k=1), then lba 198 (k=10); exactly 2 sd_wr pulses.
- Buff_we on sector 2 of track 1 during XFER of block 1: block 1 is rewritten (second sd_wr, lba 1) before busy drops.
- discard while idle with mask 0x005 gives dirty 0 next cycle. discard while busy leaves the transfer and mask untouched. A flush edge while busy produces no extra write.
- Assert reset in REQ: sd_wr and busy are 0 that cycle; a later flush with no new writes produces no sd_wr.
